// File: rtl/led_port_arbiter_pkg.sv
// Shared types and constants for the LED port arbiter slice.
package led_ctrl_pkg;
    localparam int LED_W   = 4;
    localparam int MAX_REQ = 4;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } state_t;
endpackage

// File: rtl/led_port_arbiter_if.sv
// Requester/LED-register bundle between the write sources and the arbiter.
interface led_port_arbiter_if
    import led_ctrl_pkg::*;
#(
    parameter int NREQ = 3
) ();
    logic [NREQ-1:0]       req_valid;
    logic [LED_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [LED_W-1:0]      led_data;
    logic                  led_enable;
    logic                  busy;
    logic [1:0]            last_grant;

    modport master (
        output req_valid, req_data,
        input  req_ready, led_data, led_enable, busy, last_grant
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, led_data, led_enable, busy, last_grant
    );
endinterface

// File: rtl/led_port_arbiter_rr.sv
// Combinational rotating-priority select: first valid index after last_grant.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] valid,
    input  logic [1:0]      last_grant,
    output logic [NREQ-1:0] grant,
    output logic [1:0]      index,
    output logic            any
);
    always_comb begin
        grant = '0;
        index = last_grant;
        any   = 1'b0;
        // k walks distance from last_grant; j matches the index at that distance
        for (int unsigned k = 1; k <= NREQ; k++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!any && valid[j] && (j == (32'(last_grant) + k) % NREQ)) begin
                    any      = 1'b1;
                    grant[j] = 1'b1;
                    index    = 2'(j);
                end
            end
        end
    end
endmodule

// File: rtl/led_port_arbiter.sv
// Arbitrates LED register writes among requesters, clears the LED on reset
// and enforces a hold period after every write.
module led_port_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int HOLD_CYCLES = 4
) (
    input logic               clock,
    input logic               reset,
    led_port_arbiter_if.slave bus
);
    state_t           state, state_n;
    logic [7:0]       hold_cnt;
    logic [LED_W-1:0] led_q;
    logic [1:0]       last_q;
    logic [NREQ-1:0]  grant;
    logic [1:0]       win;
    logic             any;
    logic [LED_W-1:0] sel_data;
    logic             accept;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .valid      (bus.req_valid),
        .last_grant (last_q),
        .grant      (grant),
        .index      (win),
        .any        (any)
    );

    always_comb begin
        sel_data = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (grant[j]) sel_data = bus.req_data[j*LED_W +: LED_W];
        end
    end

    assign accept = (state == IDLE) && any && !reset;

    always_comb begin
        state_n = state;
        case (state)
            CLEAR:   state_n = IDLE;
            IDLE:    if (any) state_n = WRITE;
            WRITE:   state_n = (HOLD_CYCLES == 0) ? IDLE : HOLD;
            HOLD:    if (hold_cnt == 8'd0) state_n = IDLE;
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CLEAR;
            hold_cnt <= '0;
            led_q    <= '0;
            last_q   <= 2'(NREQ - 1);
        end else begin
            state <= state_n;
            if (accept) begin
                led_q  <= sel_data;
                last_q <= win;
            end
            if (state == WRITE) begin
                if (HOLD_CYCLES != 0) hold_cnt <= 8'(HOLD_CYCLES - 1);
            end else if (state == HOLD && hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

    // Enable is decoded from the state register but masked while reset is high,
    // so a write pending in WRITE is dropped when reset lands on it.
    assign bus.led_enable = !reset && (state == CLEAR || state == WRITE);
    assign bus.req_ready  = accept ? grant : '0;
    assign bus.led_data   = led_q;
    assign bus.busy       = (state != IDLE);
    assign bus.last_grant = last_q;
endmodule

// File: tb/tb_led_port_arbiter.sv
// Directed bench for led_port_arbiter: one instance with a hold of 4, one with no hold.
module tb_led_port_arbiter;
    logic clk;
    logic rst4, rst0;
    int unsigned passed, total;

    led_port_arbiter_if #(.NREQ(3)) bus4 ();
    led_port_arbiter_if #(.NREQ(3)) bus0 ();

    led_port_arbiter #(.NREQ(3), .HOLD_CYCLES(4)) dut4 (
        .clock (clk),
        .reset (rst4),
        .bus   (bus4)
    );

    led_port_arbiter #(.NREQ(3), .HOLD_CYCLES(0)) dut0 (
        .clock (clk),
        .reset (rst0),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge, then let inputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst4 = 1'b1;
        rst0 = 1'b1;
        bus4.req_valid = '0;
        bus4.req_data  = '0;
        bus0.req_valid = '0;
        bus0.req_data  = '0;

        // Reset clear
        tick();
        tick();
        #1;
        chk("rst_enable", 32'(bus4.led_enable), 32'd0);
        chk("rst_ready", 32'(bus4.req_ready), 32'd0);
        chk("rst_last_grant", 32'(bus4.last_grant), 32'd2);
        rst4 = 1'b0;
        rst0 = 1'b0;
        #1;
        chk("clear_enable", 32'(bus4.led_enable), 32'd1);
        chk("clear_data", 32'(bus4.led_data), 32'd0);
        chk("clear_busy", 32'(bus4.busy), 32'd1);
        chk("clear_ready", 32'(bus4.req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_busy", 32'(bus4.busy), 32'd0);
            chk("idle_ready", 32'(bus4.req_ready), 32'd0);
            chk("idle_enable", 32'(bus4.led_enable), 32'd0);
        end

        // Single write of A from requester 0
        bus4.req_valid = 3'b001;
        bus4.req_data  = 12'h00A;
        #1;
        chk("single_ready", 32'(bus4.req_ready), 32'b001);
        tick();
        bus4.req_valid = 3'b000;
        #1;
        chk("single_enable", 32'(bus4.led_enable), 32'd1);
        chk("single_data", 32'(bus4.led_data), 32'hA);
        chk("single_busy_write", 32'(bus4.busy), 32'd1);
        chk("single_last", 32'(bus4.last_grant), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("single_busy_hold", 32'(bus4.busy), 32'd1);
            chk("single_enable_hold", 32'(bus4.led_enable), 32'd0);
            chk("single_data_hold", 32'(bus4.led_data), 32'hA);
        end
        tick();
        chk("single_idle", 32'(bus4.busy), 32'd0);

        // Simultaneous requests valid from reset
        rst4 = 1'b1;
        bus4.req_valid = 3'b111;
        bus4.req_data  = 12'h321;
        tick();
        rst4 = 1'b0;
        #1;
        chk("sim_clear_ready", 32'(bus4.req_ready), 32'd0);
        chk("sim_clear_data", 32'(bus4.led_data), 32'd0);
        chk("sim_clear_enable", 32'(bus4.led_enable), 32'd1);
        tick();
        for (int g = 0; g < 3; g++) begin
            chk("sim_ready", 32'(bus4.req_ready), 32'(1 << g));
            tick();
            bus4.req_valid[g] = 1'b0;
            #1;
            chk("sim_enable", 32'(bus4.led_enable), 32'd1);
            chk("sim_data", 32'(bus4.led_data), 32'(g + 1));
            chk("sim_ready_write", 32'(bus4.req_ready), 32'd0);
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("sim_ready_hold", 32'(bus4.req_ready), 32'd0);
            end
            tick();
        end
        chk("sim_last", 32'(bus4.last_grant), 32'd2);

        // Round-robin fairness: req0 continuous, req2 arrives after first grant
        bus4.req_data  = 12'h704;
        bus4.req_valid = 3'b001;
        #1;
        chk("rr_first", 32'(bus4.req_ready), 32'b001);
        tick();
        bus4.req_valid = 3'b101;
        #1;
        chk("rr_data0", 32'(bus4.led_data), 32'h4);
        for (int i = 0; i < 5; i++) tick();
        chk("rr_second", 32'(bus4.req_ready), 32'b100);
        tick();
        bus4.req_valid = 3'b001;
        #1;
        chk("rr_data2", 32'(bus4.led_data), 32'h7);
        chk("rr_last2", 32'(bus4.last_grant), 32'd2);
        for (int i = 0; i < 5; i++) tick();
        chk("rr_third", 32'(bus4.req_ready), 32'b001);
        tick();
        bus4.req_valid = 3'b000;
        #1;
        chk("rr_last0", 32'(bus4.last_grant), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("rr_idle", 32'(bus4.busy), 32'd0);

        // Reset during HOLD, then pending requests restart from requester 0
        bus4.req_data  = 12'h765;
        bus4.req_valid = 3'b010;
        #1;
        chk("mid_ready1", 32'(bus4.req_ready), 32'b010);
        tick();
        bus4.req_valid = 3'b101;
        tick();
        tick();
        chk("mid_in_hold", 32'(bus4.busy), 32'd1);
        chk("mid_data6", 32'(bus4.led_data), 32'h6);
        rst4 = 1'b1;
        #1;
        chk("mid_rst_enable", 32'(bus4.led_enable), 32'd0);
        chk("mid_rst_ready", 32'(bus4.req_ready), 32'd0);
        tick();
        rst4 = 1'b0;
        #1;
        chk("mid_clear_enable", 32'(bus4.led_enable), 32'd1);
        chk("mid_clear_data", 32'(bus4.led_data), 32'd0);
        tick();
        chk("mid_restart", 32'(bus4.req_ready), 32'b001);
        tick();
        bus4.req_valid = 3'b100;
        #1;
        chk("mid_data5", 32'(bus4.led_data), 32'h5);
        chk("mid_enable", 32'(bus4.led_enable), 32'd1);
        bus4.req_valid = 3'b000;

        // No hold: back-to-back writes on requester 1
        chk("h0_idle", 32'(bus0.busy), 32'd0);
        bus0.req_data  = 12'h090;
        bus0.req_valid = 3'b010;
        #1;
        chk("h0_ready_T", 32'(bus0.req_ready), 32'b010);
        tick();
        bus0.req_data = 12'h0C0;
        #1;
        chk("h0_enable_T1", 32'(bus0.led_enable), 32'd1);
        chk("h0_data_T1", 32'(bus0.led_data), 32'h9);
        chk("h0_ready_T1", 32'(bus0.req_ready), 32'd0);
        tick();
        chk("h0_ready_T2", 32'(bus0.req_ready), 32'b010);
        chk("h0_enable_T2", 32'(bus0.led_enable), 32'd0);
        tick();
        bus0.req_valid = 3'b000;
        #1;
        chk("h0_enable_T3", 32'(bus0.led_enable), 32'd1);
        chk("h0_data_T3", 32'(bus0.led_data), 32'hC);
        tick();
        chk("h0_idle_end", 32'(bus0.busy), 32'd0);
        chk("h0_enable_end", 32'(bus0.led_enable), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
